// File: rtl/scr_frame_ctl.sv
// STM-1 transmit scrambler frame sequencer: tracks bit/byte/row position and drives sce.
// Optional SCRCTL_BYPASS_EN adds scr_bypass, which forces sce low for line test.
module scr_frame_ctl #(
  parameter int ROWS        = 9,
  parameter int COLS        = 270,
  parameter int UNSCR_BYTES = 9,
  parameter int MISS_LIM    = 3
) (
  input  logic       clk155,
  input  logic       rst,
  input  logic       fp_in,
  input  logic       tx_en,
`ifdef SCRCTL_BYPASS_EN
  input  logic       scr_bypass,
`endif
  output logic       sce,
  output logic       fsync,
  output logic [2:0] pos_bit,
  output logic [8:0] pos_col,
  output logic [3:0] pos_row,
  output logic       fp_err,
  output logic       sync_loss
);

  localparam int MW = $clog2(MISS_LIM + 1);
  localparam logic [8:0] COL_LAST = 9'(COLS - 1);
  localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);
  localparam logic [8:0] UNSCR    = 9'(UNSCR_BYTES);
  localparam logic [MW-1:0] LIM   = MW'(MISS_LIM);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_n;
  logic [MW-1:0] miss, miss_n, miss_inc;
  logic [2:0] bit_n;
  logic [8:0] col_n;
  logic [3:0] row_n;
  logic sce_n, fsync_n, err_n, sl_n, last;

  assign last = (pos_row == ROW_LAST) &&
                (pos_col == COL_LAST) &&
                (pos_bit == 3'd7);
  assign miss_inc = miss + MW'(1);

  always_comb begin
    state_n = state;
    miss_n  = miss;
    bit_n   = '0;
    col_n   = '0;
    row_n   = '0;
    fsync_n = 1'b0;
    err_n   = 1'b0;
    sl_n    = 1'b0;
    unique case (state)
      IDLE: begin
        miss_n = '0;
        if (tx_en && fp_in) begin
          state_n = RUN;
          fsync_n = 1'b1;
        end
      end
      RUN: begin
        if (!tx_en) begin
          state_n = IDLE;
          miss_n  = '0;
        end else if (fp_in) begin
          fsync_n = 1'b1;
          miss_n  = '0;
          err_n   = !last;
        end else if (last) begin
          if (miss_inc >= LIM) begin
            state_n = IDLE;
            miss_n  = '0;
            sl_n    = 1'b1;
          end else begin
            fsync_n = 1'b1;
            miss_n  = miss_inc;
          end
        end else begin
          fsync_n = 1'b1;
          if (pos_bit == 3'd7) begin
            if (pos_col == COL_LAST) begin
              row_n = (pos_row == ROW_LAST) ? 4'd0 : pos_row + 4'd1;
            end else begin
              col_n = pos_col + 9'd1;
              row_n = pos_row;
            end
          end else begin
            bit_n = pos_bit + 3'd1;
            col_n = pos_col;
            row_n = pos_row;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // every wrap/realign lands on position 0, so the window test covers it
    sce_n = fsync_n && !((row_n == 4'd0) && (col_n < UNSCR));
`ifdef SCRCTL_BYPASS_EN
    if (scr_bypass) sce_n = 1'b0;
`endif
  end

  always_ff @(posedge clk155 or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      miss      <= '0;
      pos_bit   <= '0;
      pos_col   <= '0;
      pos_row   <= '0;
      sce       <= 1'b0;
      fsync     <= 1'b0;
      fp_err    <= 1'b0;
      sync_loss <= 1'b0;
    end else begin
      state     <= state_n;
      miss      <= miss_n;
      pos_bit   <= bit_n;
      pos_col   <= col_n;
      pos_row   <= row_n;
      sce       <= sce_n;
      fsync     <= fsync_n;
      fp_err    <= err_n;
      sync_loss <= sl_n;
    end
  end

endmodule

// File: tb/tb_scr_frame_ctl.sv
// Scoreboard bench for scr_frame_ctl using a small frame geometry.
// A linear-index frame model predicts outputs; a monitor compares them.
module tb_scr_frame_ctl;

  localparam int ROWS = 4;
  localparam int COLS = 20;
  localparam int UNB  = 3;
  localparam int LIM  = 3;
  localparam int F    = ROWS * COLS * 8;

  logic clk155 = 1'b0;
  logic rst = 1'b0;
  logic fp_in = 1'b0;
  logic tx_en = 1'b0;
  logic byp_v = 1'b0;
  logic sce, fsync, fp_err, sync_loss;
  logic [2:0] pos_bit;
  logic [8:0] pos_col;
  logic [3:0] pos_row;

  typedef struct packed {
    logic       sce;
    logic       fsync;
    logic [2:0] pbit;
    logic [8:0] col;
    logic [3:0] row;
    logic       err;
    logic       sl;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  int  p = 0;
  bit  run = 0;
  int  miss = 0;

  always #5 clk155 = ~clk155;

  scr_frame_ctl #(
    .ROWS(ROWS), .COLS(COLS), .UNSCR_BYTES(UNB), .MISS_LIM(LIM)
  ) dut (
    .clk155(clk155),
    .rst(rst),
    .fp_in(fp_in),
    .tx_en(tx_en),
`ifdef SCRCTL_BYPASS_EN
    .scr_bypass(byp_v),
`endif
    .sce(sce),
    .fsync(fsync),
    .pos_bit(pos_bit),
    .pos_col(pos_col),
    .pos_row(pos_row),
    .fp_err(fp_err),
    .sync_loss(sync_loss)
  );

  function automatic exp_t cur_out();
    exp_t o;
    o.row   = 4'(p / (COLS * 8));
    o.col   = 9'((p / 8) % COLS);
    o.pbit  = 3'(p % 8);
    o.fsync = run;
    o.sce   = run && (p >= UNB * 8) && !byp_v;
    o.err   = 1'b0;
    o.sl    = 1'b0;
    return o;
  endfunction

  task automatic step(input logic f, input logic e);
    exp_t o;
    bit err = 0;
    bit sl = 0;
    fp_in = f;
    tx_en = e;
    if (!e) begin
      run = 0; p = 0; miss = 0;
    end else if (!run) begin
      if (f) begin run = 1; p = 0; miss = 0; end
    end else if (f) begin
      err = (p != F - 1);
      p = 0; miss = 0;
    end else if (p == F - 1) begin
      miss++;
      p = 0;
      if (miss >= LIM) begin run = 0; miss = 0; sl = 1; end
    end else begin
      p++;
    end
    o = cur_out();
    o.err = err;
    o.sl  = sl;
    q.push_back(o);
    @(posedge clk155);
    #2;
  endtask

  always @(posedge clk155) begin
    exp_t ex, got;
    #1;
    if (q.size() > 0) begin
      ex  = q.pop_front();
      got = '{sce, fsync, pos_bit, pos_col, pos_row, fp_err, sync_loss};
      vectors++;
      if (got !== ex) begin
        miscompares++;
        if (miscompares <= 20)
          $display("FAIL vec t=%0t got sce=%b fs=%b r/c/b=%0d/%0d/%0d err=%b sl=%b want sce=%b fs=%b r/c/b=%0d/%0d/%0d err=%b sl=%b",
            $time, got.sce, got.fsync, got.row, got.col, got.pbit, got.err, got.sl,
            ex.sce, ex.fsync, ex.row, ex.col, ex.pbit, ex.err, ex.sl);
      end
    end
  end

  task automatic check_reset(input string tag);
    vectors++;
    if ({sce, fsync, pos_bit, pos_col, pos_row, fp_err, sync_loss} !== 19'd0) begin
      miscompares++;
      $display("FAIL %s got sce=%b fs=%b r/c/b=%0d/%0d/%0d err=%b sl=%b want all zero",
        tag, sce, fsync, pos_row, pos_col, pos_bit, fp_err, sync_loss);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    fp_in = 1'b0;
    #1;
    check_reset("async_reset");
    repeat (3) @(posedge clk155);
    #2;
    check_reset("held_reset");
    run = 0; p = 0; miss = 0;
    rst = 1'b1;
  endtask

  task automatic lock_frames(input int n);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < F && !(run && p == F - 1); c++) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
    end
  endtask

  task automatic inject_at(input int tgt);
    for (int c = 0; c < F && p != tgt; c++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
  endtask

  initial begin
    repeat (2) @(posedge clk155);
    #2;
    do_reset();

    for (int c = 0; c < 10; c++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    lock_frames(3);

    inject_at(4 % ROWS * COLS * 8 + 2 * COLS * 8 + 100 % COLS * 8 + 3);
    inject_at(1 * COLS * 8 + 7 * 8);
    inject_at(5);
    lock_frames(2);

    for (int c = 0; c < LIM * F + 40; c++) step(1'b0, 1'b1);

    step(1'b1, 1'b1);
    lock_frames(1);
    for (int c = 0; c < F && p != 2 * COLS * 8 + 37; c++) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    for (int c = 0; c < 5; c++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    lock_frames(1);

`ifdef SCRCTL_BYPASS_EN
    byp_v = 1'b1;
    lock_frames(1);
    for (int c = 0; c < 50; c++) step(1'b0, 1'b1);
    byp_v = 1'b0;
    lock_frames(1);
`endif

    for (int c = 0; c < 4000; c++) begin
      logic e, f;
      e = ($urandom_range(0, 299) != 0);
      if (run && p == F - 1) f = ($urandom_range(0, 3) != 0);
      else if (run)          f = ($urandom_range(0, 799) == 0);
      else                   f = ($urandom_range(0, 29) == 0);
`ifdef SCRCTL_BYPASS_EN
      if ($urandom_range(0, 99) == 0) byp_v = ~byp_v;
`endif
      step(f, e);
    end
    byp_v = 1'b0;

    lock_frames(1);
    for (int c = 0; c < 200; c++) step(1'b0, 1'b1);
    do_reset();
    for (int c = 0; c < 20; c++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int c = 0; c < 100; c++) step(1'b0, 1'b1);

    @(posedge clk155);
    #3;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
